uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 106, gives the clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, gives the byte FIFO entries; must be a power of two, 2..16.
REQ-003 Port clk, input, width 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, width 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, width 1: producer offers in_data this cycle.
REQ-006 Port in_data, input, width 8: byte to transmit.
REQ-007 Port in_ready, output, width 1: FIFO can accept a byte; equals "FIFO not full".
REQ-008 Port ser_tx, output, width 1: serial line, registered, idle high.
REQ-009 Port busy, output, width 1: high while a frame is on the line or the FIFO is non-empty.
REQ-010 Port fifo_level, output, width clog2(FIFO_DEPTH)+1: number of bytes queued, excluding the byte being shifted.

Function
REQ-011 A byte SHALL be accepted on a rising edge where in_valid and in_ready are both high; there is no other write path.
REQ-012 in_ready SHALL depend only on registered FIFO state, never combinationally on in_valid.
REQ-013 When full, in_ready SHALL be low even if a pop occurs in the same cycle, so there is no write-through at full.
REQ-014 in_data SHALL be ignored when in_valid is low or in_ready is low.
REQ-015 The frame FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: ser_tx=1; if the FIFO is non-empty on an edge, pop the head into the shift register, enter START, and drive ser_tx=0 from that edge.
REQ-017 Latency: a byte written on edge E into an empty FIFO with the FSM in IDLE SHALL drive ser_tx low from edge E+1.
REQ-018 START SHALL hold ser_tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-019 DATA SHALL send 8 bits, LSB first, each held CLKS_PER_BIT cycles; a 3-bit index counts 0..7, then the FSM enters PARITY or STOP (see Configuration).
REQ-020 STOP SHALL hold ser_tx=1 for CLKS_PER_BIT cycles.
REQ-021 At the end of STOP, a non-empty FIFO SHALL cause an immediate pop and entry to START on the same edge, with no idle gap between frames; an empty FIFO SHALL return the FSM to IDLE.
REQ-022 The bit-period counter SHALL be 16 bits, count 0..CLKS_PER_BIT-1, wrap to 0 at each bit boundary, and reset to 0 on every state entry.
REQ-023 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 A simultaneous push and pop on a non-full FIFO SHALL leave fifo_level unchanged.
REQ-025 fifo_level SHALL never exceed FIFO_DEPTH and never underflow.
REQ-026 A pop SHALL occur only when the FIFO is non-empty.
REQ-027 A frame in progress SHALL NOT be affected by FIFO writes.

Reset
REQ-028 While reset is high: ser_tx=1, FSM=IDLE, counters=0, FIFO pointers=0, fifo_level=0, busy=0, in_ready=0.
REQ-029 in_ready SHALL rise on the first clock edge after reset is deasserted.
REQ-030 Reset asserted mid-frame SHALL immediately force ser_tx=1, abort the frame, and discard all FIFO contents.

Configuration
REQ-031 With macro UART_TX_PARITY_EN defined, after DATA the FSM SHALL enter PARITY.
REQ-032 PARITY SHALL drive the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, then enter STOP; the frame is 11 bits.
REQ-033 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to STOP; the frame is 10 bits.

Verification
REQ-034 CLKS_PER_BIT=106, no parity: write 0x55 at edge E -> ser_tx low from E+1; mid-bit samples are start 0, data 1,0,1,0,1,0,1,0, stop 1; busy drops at E+1061.
REQ-035 Write 0x41 then 0x0A back-to-back -> the second start bit begins exactly 1060 cycles after the first; a line monitor decodes "A\n".
REQ-036 FIFO_DEPTH=4: write 6 bytes with in_valid held high -> in_ready low after the 5th accept (one byte in shift register plus 4 queued); all 6 bytes are received in order.
REQ-037 Assert reset 300 cycles into the frame for 0xA3 with 2 bytes queued -> ser_tx=1 immediately, fifo_level=0, no further frames; a new write of 0x33 is then sent intact.
REQ-038 UART_TX_PARITY_EN defined: write 0x07 -> the frame is 1166 cycles long and the parity bit is 1; write 0x03 -> the parity bit is 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO; 8 data bits, LSB first, one stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 106,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam logic [15:0]      CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("CLKS_PER_BIT must be in 2..65535");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end

  logic [2:0]       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             ser_tx_q, ser_tx_d;
  logic             rdy_en_q, rdy_en_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [7:0]       fifo_mem [FIFO_DEPTH];

  logic push, pop, fifo_empty, fifo_full, bit_done;

  // in_ready is held low during reset and the first edge after it
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_FULL);
  assign in_ready   = rdy_en_q & ~fifo_full;
  assign push       = in_valid & in_ready;
  assign bit_done   = (cnt_q == CNT_LAST);

  assign ser_tx     = ser_tx_q;
  assign busy       = (state_q != ST_IDLE) | ~fifo_empty;
  assign fifo_level = level_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_mem[rd_ptr_q];
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more bytes wait
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = fifo_mem[rd_ptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level is derived from the next state so ser_tx stays a pure flop
  always_comb begin
    ser_tx_d = 1'b1;
    case (state_d)
      ST_START:  ser_tx_d = 1'b0;
      ST_DATA:   ser_tx_d = data_d[idx_d];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: ser_tx_d = ^data_d;
`endif
      default:   ser_tx_d = 1'b1;
    endcase
  end

  always_comb begin
    rdy_en_d = 1'b1;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      ser_tx_q <= 1'b1;
      rdy_en_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ser_tx_q <= ser_tx_d;
      rdy_en_q <= rdy_en_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    if (push) begin
      fifo_mem[wr_ptr_q] <= in_data;
    end
  end

endmodule
